otp_mem_backdoor_arb: RTL and testbench

- Sits directly downstream of the FPGA OTP macro emulation, on its backing-RAM port (en/we/addr/wdata/rdata).
- Arbitrates a single-port block RAM between the OTP emulation and a host backdoor port, so FPGA software can preload and inspect fuse contents.
- Also provides a hardware zeroize sequencer that clears the whole array.
- The OTP port has absolute priority and fixed one-cycle read latency.

---
 rtl/otp_mem_backdoor_arb.sv | 139 +++++++++++++
 tb/tb_otp_mem_backdoor_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_mem_backdoor_arb.sv
// Arbitrates the OTP emulation's backing RAM port against a host backdoor and a zeroize sequencer.
// OTP has absolute priority and fixed one-cycle read latency; host and clear yield to it.
module otp_mem_backdoor_arb #(
  parameter int Width = 16,
  parameter int Depth = 1024,
  localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 otp_en_i,
  input  logic                 otp_we_i,
  input  logic [AddrWidth-1:0] otp_addr_i,
  input  logic [Width-1:0]     otp_wdata_i,
  output logic [Width-1:0]     otp_rdata_o,
  input  logic                 host_req_i,
  input  logic                 host_we_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [Width-1:0]     host_wdata_i,
  output logic                 host_gnt_o,
  output logic                 host_rvalid_o,
  output logic [Width-1:0]     host_rdata_o,
  output logic                 host_err_o,
  input  logic                 lock_i,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic                 ram_en_o,
  output logic                 ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [Width-1:0]     ram_wdata_o,
  input  logic [Width-1:0]     ram_rdata_i
);

  typedef enum logic [1:0] {
    IdleSt  = 2'd0,
    ClearSt = 2'd1
  } state_e;

  typedef enum logic [1:0] {
    TagNone = 2'd0,
    TagOtp  = 2'd1,
    TagHost = 2'd2
  } tag_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  tag_e                 tag_q, tag_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 clr_start;
  logic                 host_wr_refused;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = TagNone;
    err_d       = 1'b0;
    done_d      = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    clr_start       = (state_q == IdleSt) && clr_req_i && !lock_i;
    host_gnt_o      = host_req_i && !otp_en_i && (state_q == IdleSt) && !clr_start;
    host_wr_refused = host_we_i && lock_i;

    unique case (state_q)
      IdleSt: begin
        if (clr_start) begin
          state_d = ClearSt;
          cnt_d   = '0;
        end
      end
      ClearSt: begin
        // A reset cycle must not zero the word at the current count.
        if (!otp_en_i && rst_ni) begin
          ram_en_o = 1'b1;
          ram_we_o = 1'b1;
          ram_addr_o = cnt_q;
          if (cnt_q == LastAddr) begin
            state_d = IdleSt;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IdleSt;
    endcase

    if (host_gnt_o) begin
      tag_d = TagHost;
      err_d = host_wr_refused;
      if (!host_wr_refused) begin
        ram_en_o    = 1'b1;
        ram_we_o    = host_we_i;
        ram_addr_o  = host_addr_i;
        ram_wdata_o = host_we_i ? host_wdata_i : '0;
      end
    end

    if (otp_en_i) begin
      tag_d       = TagOtp;
      ram_en_o    = 1'b1;
      ram_we_o    = otp_we_i;
      ram_addr_o  = otp_addr_i;
      ram_wdata_o = otp_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_ni) begin
      state_q <= IdleSt;
      cnt_q   <= '0;
      tag_q   <= TagNone;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign otp_rdata_o   = ram_rdata_i;
  assign host_rdata_o  = ram_rdata_i;
  assign host_rvalid_o = (tag_q == TagHost);
  assign host_err_o    = err_q;
  assign clr_busy_o    = (state_q == ClearSt);
  assign clr_done_o    = done_q;

endmodule

// File: tb/tb_otp_mem_backdoor_arb.sv
// Directed bench for otp_mem_backdoor_arb with a behavioural RAM, a reference model of the
// arbitration/clear rules and a scoreboard of expected host responses.
module tb_otp_mem_backdoor_arb;
  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          otp_en, otp_we;
  logic [AW-1:0] otp_addr;
  logic [W-1:0]  otp_wdata, otp_rdata_o;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata, host_rdata_o;
  logic          host_gnt_o, host_rvalid_o, host_err_o;
  logic          lock, clr_req, clr_busy_o, clr_done_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [W-1:0]  ram_wdata_o, ram_rdata;

  otp_mem_backdoor_arb #(.Width(W), .Depth(D)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .otp_en_i     (otp_en),
    .otp_we_i     (otp_we),
    .otp_addr_i   (otp_addr),
    .otp_wdata_i  (otp_wdata),
    .otp_rdata_o  (otp_rdata_o),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .host_err_o   (host_err_o),
    .lock_i       (lock),
    .clr_req_i    (clr_req),
    .clr_busy_o   (clr_busy_o),
    .clr_done_o   (clr_done_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, read-first, one-cycle read latency.
  logic [W-1:0] ram_mem [D];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
      ram_rdata <= ram_mem[ram_addr_o];
    end
  end

  typedef struct {
    logic         is_read;
    logic [W-1:0] rdata;
    logic         err;
  } resp_t;

  resp_t        sb[$];
  logic [W-1:0] exp_mem [D];
  int           n_cmp, n_fail;
  int           busy_cnt, done_cnt;
  bit           m_clearing, m_done, otp_pend;
  int           m_cnt;
  logic [W-1:0] otp_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with this cycle's inputs already driven.
  task automatic tick();
    resp_t r;
    logic  exp_gnt;
    #1;
    check("clr_busy", clr_busy_o, m_clearing);
    check("clr_done", clr_done_o, m_done);
    if (clr_busy_o === 1'b1) busy_cnt++;
    if (clr_done_o === 1'b1) done_cnt++;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check("host_rvalid", host_rvalid_o, 1);
      check("host_err", host_err_o, r.err);
      if (r.is_read) check("host_rdata", host_rdata_o, r.rdata);
    end else begin
      check("host_rvalid_idle", host_rvalid_o, 0);
    end
    if (otp_pend) check("otp_rdata", otp_rdata_o, otp_exp);
    otp_pend = 0;
    m_done   = 0;
    if (!rst_n) begin
      m_clearing = 0;
    end else begin
      exp_gnt = host_req && !otp_en && !m_clearing && !(clr_req && !lock);
      check("host_gnt", host_gnt_o, exp_gnt);
      if (exp_gnt) begin
        r.is_read = !host_we;
        r.err     = host_we && lock;
        r.rdata   = exp_mem[host_addr];
        if (host_we && !lock) exp_mem[host_addr] = host_wdata;
        sb.push_back(r);
      end
      if (otp_en) begin
        if (otp_we) exp_mem[otp_addr] = otp_wdata;
        else begin
          otp_pend = 1;
          otp_exp  = exp_mem[otp_addr];
        end
      end
      if (m_clearing) begin
        if (!otp_en) begin
          exp_mem[m_cnt] = '0;
          if (m_cnt == D - 1) begin
            m_clearing = 0;
            m_done     = 1;
          end else begin
            m_cnt++;
          end
        end
      end else if (clr_req && !lock) begin
        m_clearing = 1;
        m_cnt      = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic preload();
    for (int i = 0; i < D; i++) host_op(1'b1, AW'(i), 16'h5555);
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0; busy_cnt = 0; done_cnt = 0;
    m_clearing = 0; m_done = 0; otp_pend = 0; m_cnt = 0; otp_exp = '0;
    rst_n = 1'b0; otp_en = 0; otp_we = 0; otp_addr = '0; otp_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    lock = 0; clr_req = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", clr_busy_o, 0);
    check("rst_done", clr_done_o, 0);
    check("rst_rvalid", host_rvalid_o, 0);
    check("rst_err", host_err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic host write then read.
    host_op(1'b1, 10'h010, 16'hA5A5);
    host_op(1'b0, 10'h010, '0);
    idle(1);

    // Host read held off by three OTP reads of the same word.
    host_op(1'b1, 10'h020, 16'h1234);
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h020;
    otp_en = 1'b1; otp_we = 1'b0; otp_addr = 10'h020;
    repeat (3) tick();
    otp_en = 1'b0;
    tick();
    host_req = 1'b0;
    idle(2);

    // Lock refuses host writes and clear starts.
    lock = 1'b1;
    host_op(1'b1, 10'h010, 16'hFFFF);
    host_op(1'b0, 10'h010, '0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    idle(3);
    lock = 1'b0;

    // Full clear; a second request mid-clear is ignored.
    preload();
    busy_cnt = 0; done_cnt = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 1100 && m_clearing; i++) begin
      clr_req = (i == 500);
      tick();
    end
    clr_req = 1'b0;
    idle(2);
    check("busy_cycles", busy_cnt, 1024);
    check("done_pulses", done_cnt, 1);
    host_op(1'b0, 10'h000, '0);
    host_op(1'b0, 10'h200, '0);
    host_op(1'b0, 10'h3FF, '0);
    idle(1);

    // Clear with ten OTP reads injected and a host read held throughout.
    preload();
    busy_cnt = 0; done_cnt = 0;
    clr_req = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 1200 && m_clearing; i++) begin
      otp_en   = (i % 100 == 7) && (i < 1000);
      otp_we   = 1'b0;
      otp_addr = AW'(i * 3);
      tick();
    end
    otp_en = 1'b0;
    tick();
    host_req = 1'b0;
    idle(2);
    check("busy_cycles_otp", busy_cnt, 1034);
    check("done_pulses_otp", done_cnt, 1);
    for (int i = 0; i < D; i++) host_op(1'b0, AW'(i), '0);
    idle(1);

    // Reset aborts a clear at count 100.
    preload();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 200 && m_cnt != 100; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    idle(3);
    check("done_after_rst", done_cnt, 0);
    for (int i = 0; i <= 101; i++) host_op(1'b0, AW'(i), '0);
    idle(2);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
